serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder built on the team's single-bit Full_Adder.
- Latches two operands and a carry-in on a start pulse.
- Feeds one bit pair per clock, LSB first, into a Full_Adder instance, holding the carry in a register between cycles.
- Shifts each result bit into a sum register; raises done after WIDTH bit cycles.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/Full_Adder.sv | 12 +
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/Full_Adder.sv
// Team single-bit full adder: bits[1:0] plus carryIn gives sum and carryOut.
module Full_Adder (
    input  logic [1:0] bits,
    input  logic       carryIn,
    output logic       sum,
    output logic       carryOut
);

    assign sum      = bits[1] ^ bits[0] ^ carryIn;
    assign carryOut = (bits[1] & bits[0]) | (carryIn & (bits[1] ^ bits[0]));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a Full_Adder.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_sum_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;

    logic               w_accept;
    logic               w_last;
    logic               w_fa_sum;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_sum_next;

    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
    // Partial result bits sit below the bit produced this cycle; on the last
    // cycle this is the complete sum.
    assign w_sum_next = {w_fa_sum, r_sum_sh};

    Full_Adder u_full_adder (
        .bits     ({r_b_sh[0], r_a_sh[0]}),
        .carryIn  (r_carry),
        .sum      (w_fa_sum),
        .carryOut (w_fa_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: a default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (w_last) w_next_state = DONE;
            DONE:    w_next_state = start ? SHIFT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_sum_sh <= '0;
            r_carry  <= carry_in;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_next[WIDTH-1:1];
            r_carry  <= w_fa_cout;
            r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Results update only on the final bit cycle, so outputs never show partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else if (w_last) begin
            r_sum       <= w_sum_next;
            r_carry_out <= w_fa_cout;
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic r_overflow;

    // Signed overflow: carry into the MSB cycle differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_overflow <= r_carry ^ w_fa_cout;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table plus corner sequences.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [W-1:0] sum;
    logic         carry_out;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
`ifdef SERIAL_ADDER_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .sum       (sum),
        .carry_out (carry_out)
    );

`ifndef SERIAL_ADDER_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done, counting edges and busy cycles, and noting
    // whether sum moved before completion.
    task automatic wait_done(input logic [W-1:0] prev_sum, output int cycles,
                             output int busy_cycles, output bit held);
        cycles      = 0;
        busy_cycles = 0;
        held        = 1'b1;
        while (!done && cycles < 40) begin
            if (busy) busy_cycles++;
            if (sum !== prev_sum) held = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin);
        @(posedge clk); #1;
        a        = ta;
        b        = tb;
        carry_in = tcin;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        a        = 8'hA5;
        b        = 8'h5A;
        carry_in = ~tcin;
    endtask

    vec_t vecs [7];

    initial begin
        int          cycles;
        int          busy_cycles;
        bit          held;
        logic [W-1:0] prev;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset carry_out", carry_out, 0);
        check("reset overflow", overflow, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            prev = sum;
            pulse_start(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(prev, cycles, busy_cycles, held);
            check($sformatf("vec%0d latency", i), cycles, W);
            check($sformatf("vec%0d busy cycles", i), busy_cycles, W);
            check($sformatf("vec%0d sum held", i), held, 1);
            check($sformatf("vec%0d sum", i), sum, vecs[i].sum);
            check($sformatf("vec%0d carry_out", i), carry_out, vecs[i].cout);
`ifdef SERIAL_ADDER_OVERFLOW_EN
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].ovf);
`endif
            @(posedge clk); #1;
            check($sformatf("vec%0d done pulse", i), done, 0);
            check($sformatf("vec%0d idle", i), busy, 0);
        end

        // start pulsed mid-SHIFT with different operands must be ignored
        prev = sum;
        pulse_start(8'h10, 8'h20, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(prev, cycles, busy_cycles, held);
        check("ignore latency", cycles, W - 3);
        check("ignore sum", sum, 8'h30);
        check("ignore carry_out", carry_out, 0);
        @(posedge clk); #1;
        check("ignore no restart", busy, 0);

        // back-to-back: second operands presented while busy, start held through DONE
        prev = sum;
        pulse_start(8'h0F, 8'h01, 1'b0);
        a     = 8'h01;
        b     = 8'h02;
        carry_in = 1'b0;
        start = 1'b1;
        wait_done(prev, cycles, busy_cycles, held);
        check("b2b first latency", cycles, W);
        check("b2b first sum", sum, 8'h10);
        @(posedge clk); #1;
        start = 1'b0;
        a     = 8'hEE;
        check("b2b restart busy", busy, 1);
        wait_done(8'h10, cycles, busy_cycles, held);
        check("b2b second spacing", cycles + 1, W + 1);
        check("b2b second sum held", held, 1);
        check("b2b second sum", sum, 8'h03);
        check("b2b second carry_out", carry_out, 0);
        @(posedge clk); #1;

        // prime carry_out=1, then reset mid-operation
        pulse_start(8'hFF, 8'h01, 1'b0);
        wait_done(8'h03, cycles, busy_cycles, held);
        check("pre-reset carry_out", carry_out, 1);
        pulse_start(8'h80, 8'h80, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("abort busy before reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sum", sum, 0);
        check("abort carry_out", carry_out, 0);
        cycles = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 2) rst_n = 1'b1;
            if (done) cycles++;
        end
        check("abort no done", cycles, 0);
        check("abort sum stays", sum, 0);

        pulse_start(8'h01, 8'h01, 1'b0);
        wait_done(8'h00, cycles, busy_cycles, held);
        check("post-reset latency", cycles, W);
        check("post-reset sum", sum, 8'h02);
        check("post-reset carry_out", carry_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
